// File: rtl/move_scheduler.sv
// move_scheduler
//   Turn-order controller between the local and remote move sources, game_fsm
//   and the board tx link. One move is in flight at a time: it is admitted,
//   range-checked, issued to game_fsm, and after a legal local move the board
//   state is transmitted before the turn passes to the other colour.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   local_color             colour played by this board (0 black, 1 white)
//   local_valid/move/ready  held local request, accepted on valid & ready
//   remote_valid/move       single-cycle remote move strobe from rx
//   move_avail, move        one-cycle issue strobe + move to game_fsm
//   move_done, move_illegal verdict pulses from game_fsm
//   tx_trigger, tx_busy     board-state send strobe / tx serialising flag
//   turn                    colour to move
//   reject, stray           dropped-move pulses (bad/illegal, off-turn remote)
//   fault                   sticky timeout flag
module move_scheduler #(
    parameter int MOVE_W      = 8,
    parameter int TIMEOUT_CYC = 65_000_000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              local_color,
    input  logic              local_valid,
    input  logic [MOVE_W-1:0] local_move,
    output logic              local_ready,
    input  logic              remote_valid,
    input  logic [MOVE_W-1:0] remote_move,
    output logic              move_avail,
    output logic [MOVE_W-1:0] move,
    input  logic              move_done,
    input  logic              move_illegal,
    output logic              tx_trigger,
    input  logic              tx_busy,
    output logic              turn,
    output logic              reject,
    output logic              stray,
    output logic              fault
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int HALF  = MOVE_W / 2;
    localparam logic [HALF-1:0]  MAX_IDX   = HALF'(8);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] NOBUSY_LAST = CNT_W'(3);
    localparam logic SRC_LOCAL  = 1'b0;
    localparam logic SRC_REMOTE = 1'b1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_GAME, SEND, WAIT_TX, FAULT} state_t;

    state_t            state, state_d;
    logic              turn_d, src, src_d, seen_busy, seen_d;
    logic              avail_d, trig_d, reject_d, stray_d, fault_d;
    logic [MOVE_W-1:0] move_d, acc_move;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              remote_ok, local_acc, remote_acc, in_range, tx_done;

    assign local_ready = (state == IDLE) && (turn == local_color) && !fault;
    assign remote_ok   = (state == IDLE) && (turn != local_color) && !fault;
    assign local_acc   = local_valid && local_ready;
    assign remote_acc  = remote_valid && remote_ok;
    // Only one of the two can be accepted in a given cycle (turn decides).
    assign acc_move    = local_acc ? local_move : remote_move;
    assign in_range    = (acc_move[MOVE_W-1:HALF] <= MAX_IDX) && (acc_move[HALF-1:0] <= MAX_IDX);
    // Send completes on a seen busy->idle fall, or when busy never showed up
    // in the four cycles following the trigger.
    assign tx_done     = seen_busy ? !tx_busy : (!tx_busy && cnt == NOBUSY_LAST);

    always_comb begin
        state_d  = state;
        turn_d   = turn;
        move_d   = move;
        src_d    = src;
        seen_d   = seen_busy;
        cnt_d    = cnt + CNT_W'(1);
        avail_d  = 1'b0;
        trig_d   = 1'b0;
        reject_d = 1'b0;
        stray_d  = 1'b0;
        fault_d  = fault;

        if (remote_valid && !remote_ok && state != FAULT)
            stray_d = 1'b1;

        case (state)
            IDLE: begin
                if (local_acc || remote_acc) begin
                    move_d = acc_move;
                    src_d  = local_acc ? SRC_LOCAL : SRC_REMOTE;
                    if (in_range) begin
                        state_d = ISSUE;
                        avail_d = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT_GAME;
            WAIT_GAME: begin
                // A verdict on the last counted cycle still wins over timeout.
                if (move_illegal) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else if (move_done) begin
                    if (src == SRC_LOCAL) begin
                        state_d = SEND;
                        trig_d  = 1'b1;
                    end else begin
                        turn_d  = ~turn;
                        state_d = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end
            end
            SEND: begin
                state_d = WAIT_TX;
                seen_d  = 1'b0;
            end
            WAIT_TX: begin
                if (tx_busy)
                    seen_d = 1'b1;
                if (tx_done) begin
                    turn_d  = ~turn;
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (state_d != state)
            cnt_d = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            turn       <= 1'b0;
            move       <= '0;
            src        <= SRC_LOCAL;
            seen_busy  <= 1'b0;
            cnt        <= '0;
            move_avail <= 1'b0;
            tx_trigger <= 1'b0;
            reject     <= 1'b0;
            stray      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_d;
            turn       <= turn_d;
            move       <= move_d;
            src        <= src_d;
            seen_busy  <= seen_d;
            cnt        <= cnt_d;
            move_avail <= avail_d;
            tx_trigger <= trig_d;
            reject     <= reject_d;
            stray      <= stray_d;
            fault      <= fault_d;
        end
    end
endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler
//   Directed bench for move_scheduler with a 16-cycle timeout. Inputs change
//   1 time unit after a rising edge; outputs are read at the same point.
module tb_move_scheduler;
    logic       clk = 1'b0;
    logic       rst_in;
    logic       local_color;
    logic       local_valid;
    logic [7:0] local_move;
    logic       local_ready;
    logic       remote_valid;
    logic [7:0] remote_move;
    logic       move_avail;
    logic [7:0] move;
    logic       move_done;
    logic       move_illegal;
    logic       tx_trigger;
    logic       tx_busy;
    logic       turn;
    logic       reject;
    logic       stray;
    logic       fault;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    move_scheduler #(.MOVE_W(8), .TIMEOUT_CYC(16)) dut (
        .clk_in(clk), .rst_in(rst_in), .local_color(local_color),
        .local_valid(local_valid), .local_move(local_move), .local_ready(local_ready),
        .remote_valid(remote_valid), .remote_move(remote_move),
        .move_avail(move_avail), .move(move), .move_done(move_done),
        .move_illegal(move_illegal), .tx_trigger(tx_trigger), .tx_busy(tx_busy),
        .turn(turn), .reject(reject), .stray(stray), .fault(fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; local_color = 1'b1;
        local_valid = 1'b0; local_move = 8'h00; remote_valid = 1'b0; remote_move = 8'h00;
        move_done = 1'b0; move_illegal = 1'b0; tx_busy = 1'b0;
        tick(); tick();
        checks++; if (local_ready !== 1'b0) $display("FAIL reset_ready_white got %b want 0", local_ready); else passes++;
        local_color = 1'b0;
        #1;
        checks++; if ({turn, move, move_avail, tx_trigger, reject, stray, fault, local_ready} !== {1'b0, 8'h00, 5'b0, 1'b1})
            $display("FAIL reset_state got t%b m%h a%b x%b r%b s%b f%b l%b want t0 m00 all0 l1",
                     turn, move, move_avail, tx_trigger, reject, stray, fault, local_ready);
        else passes++;
        rst_in = 1'b0;
    endtask

    task automatic test_local_move();
        int trig_cnt = 0;
        local_valid = 1'b1; local_move = 8'h34;
        tick();
        local_valid = 1'b0;
        checks++; if ({move_avail, move} !== {1'b1, 8'h34}) $display("FAIL local_issue got a%b m%h want a1 m34", move_avail, move); else passes++;
        tick();
        checks++; if (move_avail !== 1'b0) $display("FAIL local_avail_1cyc got %b want 0", move_avail); else passes++;
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        checks++; if (tx_trigger !== 1'b1) $display("FAIL local_trigger got %b want 1", tx_trigger); else passes++;
        tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_trigger) trig_cnt++;
        end
        checks++; if ({trig_cnt, turn} !== {32'd0, 1'b0}) $display("FAIL local_during_tx got trig%0d t%b want trig0 t0", trig_cnt, turn); else passes++;
        tx_busy = 1'b0;
        tick();
        checks++; if ({turn, local_ready} !== 2'b10) $display("FAIL local_turn_pass got t%b l%b want t1 l0", turn, local_ready); else passes++;
    endtask

    task automatic test_remote_move();
        int trig_cnt = 0;
        remote_valid = 1'b1; remote_move = 8'h80;
        tick();
        remote_valid = 1'b0;
        checks++; if ({move_avail, move, stray} !== {1'b1, 8'h80, 1'b0}) $display("FAIL remote_issue got a%b m%h s%b want a1 m80 s0", move_avail, move, stray); else passes++;
        tick();
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        if (tx_trigger) trig_cnt++;
        checks++; if ({turn, local_ready} !== 2'b01) $display("FAIL remote_turn_back got t%b l%b want t0 l1", turn, local_ready); else passes++;
        tick();
        if (tx_trigger) trig_cnt++;
        checks++; if (trig_cnt !== 0) $display("FAIL remote_no_tx got %0d want 0", trig_cnt); else passes++;
        remote_valid = 1'b1; remote_move = 8'h11;
        tick();
        remote_valid = 1'b0;
        checks++; if ({stray, move_avail, move} !== {1'b1, 1'b0, 8'h80}) $display("FAIL stray_off_turn got s%b a%b m%h want s1 a0 m80", stray, move_avail, move); else passes++;
        tick();
        checks++; if (stray !== 1'b0) $display("FAIL stray_1cyc got %b want 0", stray); else passes++;
    endtask

    task automatic test_reject();
        local_valid = 1'b1; local_move = 8'h49;
        tick();
        local_valid = 1'b0;
        checks++; if ({reject, move_avail} !== 2'b10) $display("FAIL range_reject got r%b a%b want r1 a0", reject, move_avail); else passes++;
        tick();
        checks++; if ({reject, turn, local_ready, move_avail} !== 4'b0010) $display("FAIL range_after got r%b t%b l%b a%b want r0 t0 l1 a0", reject, turn, local_ready, move_avail); else passes++;
        local_valid = 1'b1; local_move = 8'h00;
        tick();
        local_valid = 1'b0;
        checks++; if ({move_avail, move} !== {1'b1, 8'h00}) $display("FAIL corner00_issue got a%b m%h want a1 m00", move_avail, move); else passes++;
        tick();
        move_illegal = 1'b1;
        tick();
        move_illegal = 1'b0;
        checks++; if ({reject, turn, local_ready, tx_trigger} !== 4'b1010) $display("FAIL illegal got r%b t%b l%b x%b want r1 t0 l1 x0", reject, turn, local_ready, tx_trigger); else passes++;
        // Both verdict pulses together count as illegal.
        local_valid = 1'b1; local_move = 8'h12;
        tick();
        local_valid = 1'b0;
        tick();
        move_done = 1'b1; move_illegal = 1'b1;
        tick();
        move_done = 1'b0; move_illegal = 1'b0;
        checks++; if ({reject, tx_trigger, turn, local_ready} !== 4'b1001) $display("FAIL done_and_illegal got r%b x%b t%b l%b want r1 x0 t0 l1", reject, tx_trigger, turn, local_ready); else passes++;
    endtask

    task automatic test_tx_no_busy();
        local_valid = 1'b1; local_move = 8'h88;
        tick();
        local_valid = 1'b0;
        checks++; if ({move_avail, move} !== {1'b1, 8'h88}) $display("FAIL corner88_issue got a%b m%h want a1 m88", move_avail, move); else passes++;
        tick();
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        checks++; if (tx_trigger !== 1'b1) $display("FAIL nobusy_trigger got %b want 1", tx_trigger); else passes++;
        tick(); tick(); tick(); tick();
        checks++; if (turn !== 1'b0) $display("FAIL nobusy_early got t%b want 0", turn); else passes++;
        tick();
        checks++; if (turn !== 1'b1) $display("FAIL nobusy_done got t%b want 1", turn); else passes++;
    endtask

    task automatic test_hold_and_collide();
        int seen_avail = 0;
        local_valid = 1'b1; local_move = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (move_avail) seen_avail++;
        end
        checks++; if ({seen_avail, local_ready} !== {32'd0, 1'b0}) $display("FAIL hold_remote_turn got a%0d l%b want a0 l0", seen_avail, local_ready); else passes++;
        remote_valid = 1'b1; remote_move = 8'h23;
        tick();
        remote_valid = 1'b0;
        checks++; if ({move_avail, move} !== {1'b1, 8'h23}) $display("FAIL hold_remote_issue got a%b m%h want a1 m23", move_avail, move); else passes++;
        tick();
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        checks++; if ({turn, local_ready} !== 2'b01) $display("FAIL hold_turn_back got t%b l%b want t0 l1", turn, local_ready); else passes++;
        tick();
        local_valid = 1'b0;
        checks++; if ({move_avail, move} !== {1'b1, 8'h22}) $display("FAIL hold_accepted got a%b m%h want a1 m22", move_avail, move); else passes++;
        tick();
        move_illegal = 1'b1;
        tick();
        move_illegal = 1'b0;
        local_valid = 1'b1; local_move = 8'h33; remote_valid = 1'b1; remote_move = 8'h44;
        tick();
        local_valid = 1'b0; remote_valid = 1'b0;
        checks++; if ({move_avail, move, stray} !== {1'b1, 8'h33, 1'b1}) $display("FAIL collide got a%b m%h s%b want a1 m33 s1", move_avail, move, stray); else passes++;
        tick();
        move_illegal = 1'b1;
        tick();
        move_illegal = 1'b0;
    endtask

    task automatic test_timeout();
        local_valid = 1'b1; local_move = 8'h11;
        tick();
        local_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (fault !== 1'b0) $display("FAIL timeout_early got %b want 0", fault); else passes++;
        tick();
        checks++; if (fault !== 1'b1) $display("FAIL timeout_fault got %b want 1", fault); else passes++;
        move_done = 1'b1; remote_valid = 1'b1; remote_move = 8'h55; local_valid = 1'b1; local_move = 8'h66;
        tick();
        move_done = 1'b0; remote_valid = 1'b0; local_valid = 1'b0;
        checks++; if ({move_avail, stray, reject, tx_trigger, local_ready, fault, move} !== {5'b0, 1'b1, 8'h11})
            $display("FAIL fault_ignores got a%b s%b r%b x%b l%b f%b m%h want all0 f1 m11",
                     move_avail, stray, reject, tx_trigger, local_ready, fault, move);
        else passes++;
        tick();
        checks++; if (fault !== 1'b1) $display("FAIL fault_sticky got %b want 1", fault); else passes++;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++; if ({fault, turn, local_ready} !== 3'b001) $display("FAIL fault_reset got f%b t%b l%b want f0 t0 l1", fault, turn, local_ready); else passes++;
    endtask

    task automatic test_reset_mid_tx();
        local_valid = 1'b1; local_move = 8'h57;
        tick();
        local_valid = 1'b0;
        tick();
        move_done = 1'b1;
        tick();
        move_done = 1'b0;
        tx_busy = 1'b1;
        tick(); tick(); tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++; if ({tx_trigger, turn, local_ready, move} !== {3'b001, 8'h00}) $display("FAIL mid_reset got x%b t%b l%b m%h want x0 t0 l1 m00", tx_trigger, turn, local_ready, move); else passes++;
        tick(); tick();
        tx_busy = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if ({turn, local_ready} !== 2'b01) $display("FAIL mid_reset_no_toggle got t%b l%b want t0 l1", turn, local_ready); else passes++;
    endtask

    initial begin
        test_reset();
        test_local_move();
        test_remote_move();
        test_reject();
        test_tx_no_busy();
        test_hold_and_collide();
        test_timeout();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
